// File: rtl/game_regs_pkg.sv
// -----------------------------------------------------------------------------
// game_regs_pkg
// Shared definitions for the game-state register block:
//   - register offsets inside the 256-byte window
//   - staged/live field widths and reset values
//   - CTRL register bit positions
//   - handshake FSM state type
//   - packed record holding the seven game fields
//   - byte-lane merge helper used for partial CPU writes
// -----------------------------------------------------------------------------
package game_regs_pkg;

    // Register offsets (byte addresses, word aligned)
    localparam logic [7:0] OFF_CHAR_X     = 8'h00;
    localparam logic [7:0] OFF_CHAR_Y     = 8'h04;
    localparam logic [7:0] OFF_OBST_X     = 8'h08;
    localparam logic [7:0] OFF_SCORE      = 8'h0C;
    localparam logic [7:0] OFF_STATUS     = 8'h10;
    localparam logic [7:0] OFF_OBST_H_BOT = 8'h14;
    localparam logic [7:0] OFF_OBST_H_TOP = 8'h18;
    localparam logic [7:0] OFF_CTRL       = 8'h1C;
    localparam logic [7:0] OFF_FRAME_CNT  = 8'h20;

    // Field widths
    localparam int W_CHAR_X     = 10;
    localparam int W_CHAR_Y     = 10;
    localparam int W_OBST_X     = 11;
    localparam int W_SCORE      = 16;
    localparam int W_STATUS     = 1;
    localparam int W_OBST_H     = 10;
    localparam int W_FRAME_CNT  = 16;

    // Reset values (CHAR_X reset value is a top-level parameter)
    localparam logic [W_CHAR_Y-1:0]    RST_CHAR_Y     = 10'd300;
    localparam logic [W_OBST_X-1:0]    RST_OBST_X     = 11'd640;
    localparam logic [W_SCORE-1:0]     RST_SCORE      = 16'd0;
    localparam logic [W_STATUS-1:0]    RST_STATUS     = 1'b0;
    localparam logic [W_OBST_H-1:0]    RST_OBST_H_BOT = 10'd80;
    localparam logic [W_OBST_H-1:0]    RST_OBST_H_TOP = 10'd80;

    // CTRL register bit positions
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_AUTO_BIT   = 1;

    // Handshake FSM states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    // One complete set of game fields (used for both staged and live banks)
    typedef struct packed {
        logic [W_CHAR_X-1:0]  char_x;
        logic [W_CHAR_Y-1:0]  char_y;
        logic [W_OBST_X-1:0]  obst_x;
        logic [W_SCORE-1:0]   score;
        logic [W_STATUS-1:0]  status;
        logic [W_OBST_H-1:0]  obst_h_bot;
        logic [W_OBST_H-1:0]  obst_h_top;
    } game_fields_t;

    // Replace the bytes of cur selected by wstrb with the matching bytes of wdata
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                res[8*b +: 8] = cur[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/game_regs_mmio.sv
// -----------------------------------------------------------------------------
// game_regs_mmio
// PicoRV32 native-bus slave holding the game-state registers for the VGA
// renderer. CPU writes land in a staged bank; the live bank driving the
// renderer copies the staged bank only on frame_start (when a commit is
// pending or AUTO is set), so the picture never tears mid-frame. A frame
// counter lets the CPU pace itself.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mem_valid/mem_instr   CPU request valid / instruction-fetch flag
//   mem_addr/wdata/wstrb  byte address, write data, byte strobes (0 = read)
//   mem_ready/mem_rdata   one-cycle response strobe and read data
//   sel                   combinational window hit
//   frame_start           one-cycle pulse at the start of vertical blank
//   char_x .. obstacle_height_top   live bank outputs to the renderer
// -----------------------------------------------------------------------------
module game_regs_mmio
    import game_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFF10_0000,
    parameter bit          CHAR_X_LOCK  = 1'b1,
    parameter logic [9:0]  CHAR_X_RESET = 10'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sel,
    input  logic        frame_start,
    output logic [9:0]  char_x,
    output logic [9:0]  char_y,
    output logic [10:0] obstacle_x,
    output logic [15:0] score,
    output logic        game_status,
    output logic [9:0]  obstacle_height_bottom,
    output logic [9:0]  obstacle_height_top
);

    // Reset image shared by the staged and live banks
    localparam game_fields_t FIELDS_RST = {CHAR_X_RESET, RST_CHAR_Y, RST_OBST_X,
                                           RST_SCORE, RST_STATUS,
                                           RST_OBST_H_BOT, RST_OBST_H_TOP};

    state_e                 state_q, state_d;
    game_fields_t           staged_q, staged_d;
    game_fields_t           live_q, live_d;
    logic                   pending_q, pending_d;
    logic                   auto_q, auto_d;
    logic [W_FRAME_CNT-1:0] fcnt_q, fcnt_d;
    logic                   ready_q, ready_d;
    logic [31:0]            rdata_q, rdata_d;

    logic                   accept_s;
    logic                   wr_s;
    logic [7:0]             off_s;
    logic [31:0]            rd_val_s;
    logic [31:0]            merged_s;
    logic                   unused_bits_s;

    assign sel      = mem_valid & ~mem_instr & (mem_addr[31:8] == BASE_ADDR[31:8]);
    // A request is only taken in IDLE; the RESP cycle never looks at the bus.
    assign accept_s = sel & (state_q == S_IDLE);
    assign wr_s     = accept_s & (mem_wstrb != 4'b0000);
    assign off_s    = {mem_addr[7:2], 2'b00};
    assign merged_s = merge_bytes(rd_val_s, mem_wdata, mem_wstrb);

    // Byte-offset bits and the upper merge bits of narrow fields carry no information
    assign unused_bits_s = ^{mem_addr[1:0], merged_s[31:16]};

    // Zero-extended readback of the addressed register (also the merge base for writes)
    always_comb begin
        rd_val_s = 32'd0;
        case (off_s)
            OFF_CHAR_X:     rd_val_s = {22'd0, staged_q.char_x};
            OFF_CHAR_Y:     rd_val_s = {22'd0, staged_q.char_y};
            OFF_OBST_X:     rd_val_s = {21'd0, staged_q.obst_x};
            OFF_SCORE:      rd_val_s = {16'd0, staged_q.score};
            OFF_STATUS:     rd_val_s = {31'd0, staged_q.status};
            OFF_OBST_H_BOT: rd_val_s = {22'd0, staged_q.obst_h_bot};
            OFF_OBST_H_TOP: rd_val_s = {22'd0, staged_q.obst_h_top};
            OFF_CTRL:       rd_val_s = {30'd0, auto_q, pending_q};
            OFF_FRAME_CNT:  rd_val_s = {16'd0, fcnt_q};
            default:        rd_val_s = 32'd0;
        endcase
    end

    // Handshake FSM next state and registered response
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    // Writes return zero; reads return the value at acceptance.
                    if (wr_s) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = rd_val_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Staged/live banks, commit control and frame counter
    always_comb begin
        staged_d  = staged_q;
        live_d    = live_q;
        pending_d = pending_q;
        auto_d    = auto_q;
        fcnt_d    = fcnt_q;

        // Frame boundary: live copies the staged bank as it stood before any
        // write landing in this same cycle.
        if (frame_start) begin
            fcnt_d = fcnt_q + 16'd1;
            if (pending_q | auto_q) begin
                live_d    = staged_q;
                pending_d = 1'b0;
            end else begin
                live_d    = live_q;
            end
        end else begin
            fcnt_d = fcnt_q;
        end

        // CPU write is applied after the frame logic so that a COMMIT set and a
        // FRAME_CNT clear both win over the simultaneous frame_start effects.
        if (wr_s) begin
            case (off_s)
                OFF_CHAR_X: begin
                    if (!CHAR_X_LOCK) begin
                        staged_d.char_x = merged_s[W_CHAR_X-1:0];
                    end else begin
                        staged_d.char_x = staged_q.char_x;
                    end
                end
                OFF_CHAR_Y:     staged_d.char_y     = merged_s[W_CHAR_Y-1:0];
                OFF_OBST_X:     staged_d.obst_x     = merged_s[W_OBST_X-1:0];
                OFF_SCORE:      staged_d.score      = merged_s[W_SCORE-1:0];
                OFF_STATUS:     staged_d.status     = merged_s[W_STATUS-1:0];
                OFF_OBST_H_BOT: staged_d.obst_h_bot = merged_s[W_OBST_H-1:0];
                OFF_OBST_H_TOP: staged_d.obst_h_top = merged_s[W_OBST_H-1:0];
                OFF_CTRL: begin
                    // COMMIT is write-one-to-set; writing 0 leaves pending alone.
                    if (mem_wstrb[0] & mem_wdata[CTRL_COMMIT_BIT]) begin
                        pending_d = 1'b1;
                    end else begin
                        pending_d = pending_d;
                    end
                    auto_d = merged_s[CTRL_AUTO_BIT];
                end
                OFF_FRAME_CNT:  fcnt_d = 16'd0;
                default: begin
                    staged_d = staged_d;
                end
            endcase
        end else begin
            staged_d = staged_d;
        end
    end

    // State, bank and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            staged_q  <= FIELDS_RST;
            live_q    <= FIELDS_RST;
            pending_q <= 1'b0;
            auto_q    <= 1'b0;
            fcnt_q    <= 16'd0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            staged_q  <= staged_d;
            live_q    <= live_d;
            pending_q <= pending_d;
            auto_q    <= auto_d;
            fcnt_q    <= fcnt_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Reset raised during the response cycle cancels that response outright.
    assign mem_ready = ready_q & ~reset;
    assign mem_rdata = reset ? 32'd0 : rdata_q;

    assign char_x                 = live_q.char_x;
    assign char_y                 = live_q.char_y;
    assign obstacle_x             = live_q.obst_x;
    assign score                  = live_q.score;
    assign game_status            = live_q.status;
    assign obstacle_height_bottom = live_q.obst_h_bot;
    assign obstacle_height_top    = live_q.obst_h_top;

endmodule
